uart_byte_tx: RTL and testbench
===============================

Name: uart_byte_tx

Overview:
- 8N1 UART transmitter that directly consumes the byte stream produced by the image sender stage (pixel RGB and coordinate bytes).
- Accepts one byte per ld_tx_data pulse into a single holding register and advertises free space via tx_empty.
- Serialises bytes onto the board TX pin at a fixed baud rate.
- Double buffered (holding register plus shift register) so the upstream stage can queue the next byte while the current one is on the wire.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
DATA_BITS, 8, data bits per frame; fixed at 8 for this design, but the counter is sized from this parameter

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
tx_data  input  8  byte to transmit, sampled on ld_tx_data
ld_tx_data  input  1  load strobe, one cycle; accepted only while tx_empty=1
tx_enable  input  1  permits starting new frames; low holds off the start of any new frame
tx_empty  output  1  holding register empty, can accept a byte
tx_busy  output  1  a frame (start/data/stop) is currently on the line
tx_overrun  output  1  sticky: ld_tx_data seen while tx_empty=0
tx_out  output  1  serial line, idle high, registered

Behaviour:
- Clock, reset and registers:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - All state is held in registers; tx_out is driven straight from a flop, with no glitching path.
- Reset values: tx_out=1, tx_empty=1, tx_busy=0, tx_overrun=0, FSM=IDLE, baud counter=0, bit index=0, holding register=0.
- Reset asserted mid-frame: tx_out returns to 1 immediately (asynchronously); the partial frame is abandoned; the held byte is discarded.
- Load:
  - On a clk edge with ld_tx_data=1 and tx_empty=1, hold <= tx_data and tx_empty <= 0.
  - ld_tx_data while tx_empty=0 is ignored: hold is unchanged and tx_overrun <= 1. tx_overrun is cleared only by reset.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If tx_empty=0 and tx_enable=1, then shift <= hold, tx_empty <= 1, go to START.
  - Otherwise stay; tx_out=1, tx_busy=0.
- START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_out=shift[bit index], LSB first; each bit lasts CLKS_PER_BIT cycles.
  - After bit DATA_BITS-1, go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles. On the last cycle of STOP:
  - If tx_empty=0 and tx_enable=1, transfer hold to shift, set tx_empty=1 and go to START. The result is back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- tx_busy is 1 in START, DATA and STOP.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and resets to 0 on each bit boundary.
  - It is held at 0 in IDLE, so every frame is aligned to its own start.
- Latency: the edge that samples ld_tx_data (with the FSM idle) is edge E0. The transfer happens at E1, and tx_out falls after edge E2. One frame is exactly 10*CLKS_PER_BIT cycles.
- tx_enable is sampled only at frame-start decisions. Dropping it mid-frame does not truncate the frame; the frame completes, then the block idles with the byte still held.
- Simultaneous load and transfer cannot occur: load requires empty and transfer requires full.
- tx_empty can rise (transfer) in the same cycle as a new ld_tx_data is presented. That load is rejected, because it is evaluated against the pre-edge tx_empty=0, and tx_overrun is set. The upstream stage must wait until it sees tx_empty=1.

Test Plan:
- CLKS_PER_BIT=4; reset, then ld 0xA5 with tx_enable=1 -> tx_out falls 2 edges after load, then line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_busy high for 40 cycles; tx_empty back to 1 one edge after load+1.
- Back-to-back: load 0x55, then load 0x0F as soon as tx_empty=1 -> 80 contiguous busy cycles; no idle-high cycles between the first stop bit and the second start bit; second frame bits 1,1,1,1,0,0,0,0 LSB first.
- Overrun: load 0x11, then load 0x22 while tx_empty=0 (first byte still held) -> tx_overrun=1 and stays 1; only 0x11 is transmitted.
- tx_enable=0, load 0x3C -> tx_out stays 1 and tx_empty=0 indefinitely; raise tx_enable -> frame for 0x3C starts 2 edges later. Drop tx_enable mid-DATA -> the frame still completes all 10 bits.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx_out=1 asynchronously, tx_empty=1, tx_busy=0, tx_overrun=0. After release, the next load transmits a clean full frame.
- Default CLKS_PER_BIT=434: send 0x00 -> start bit plus 8 data zeros give tx_out low for exactly 3906 cycles, then high for 434 cycles.

Source files
------------

// File: rtl/uart_byte_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : uart_byte_tx
// Brief    : 8N1 UART transmitter, holding register + shift register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 ld_tx_data,
    input  logic                 tx_enable,
    output logic                 tx_empty,
    output logic                 tx_busy,
    output logic                 tx_overrun,
    output logic                 tx_out
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_empty;
    logic                 r_overrun;
    logic                 r_tx_out;
    logic                 r_busy;
    logic                 w_bit_done;
    logic                 w_can_start;
    logic                 w_xfer;
    logic                 w_tx_out_next;
    logic                 w_busy_next;

    assign w_bit_done  = (r_baud_cnt == c_LAST_CNT);
    assign w_can_start = ~r_empty & tx_enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A frame start (from IDLE or the last STOP cycle) always moves hold into shift.
    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_can_start) begin
                    w_state_next = c_START;
                    w_xfer       = 1'b1;
                end
            end
            c_START: begin
                if (w_bit_done) begin
                    w_state_next = c_DATA;
                end
            end
            c_DATA: begin
                if (w_bit_done && (r_bit_idx == c_LAST_IDX)) begin
                    w_state_next = c_STOP;
                end
            end
            c_STOP: begin
                if (w_bit_done) begin
                    if (w_can_start) begin
                        w_state_next = c_START;
                        w_xfer       = 1'b1;
                    end else begin
                        w_state_next = c_IDLE;
                    end
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_tx_out_next = 1'b1;
        w_busy_next   = 1'b1;
        case (r_state)
            c_IDLE:  w_busy_next   = 1'b0;
            c_START: w_tx_out_next = 1'b0;
            c_DATA:  w_tx_out_next = r_shift[r_bit_idx];
            default: w_tx_out_next = 1'b1;
        endcase
    end

    // Line and busy flag share one register stage so busy tracks the wire exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_tx_out <= w_tx_out_next;
            r_busy   <= w_busy_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
        end else if (r_state == c_IDLE) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
        end else begin
            r_baud_cnt <= w_bit_done ? '0 : r_baud_cnt + 1'b1;
            if (r_state == c_START) begin
                r_bit_idx <= '0;
            end else if ((r_state == c_DATA) && w_bit_done) begin
                r_bit_idx <= (r_bit_idx == c_LAST_IDX) ? '0 : r_bit_idx + 1'b1;
            end
        end
    end

    // Load and transfer are mutually exclusive: load needs empty, transfer needs full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_shift   <= '0;
            r_empty   <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            if (ld_tx_data && r_empty) begin
                r_hold  <= tx_data;
                r_empty <= 1'b0;
            end else if (w_xfer) begin
                r_shift <= r_hold;
                r_empty <= 1'b1;
            end
            if (ld_tx_data && !r_empty) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign tx_empty   = r_empty;
    assign tx_busy    = r_busy;
    assign tx_overrun = r_overrun;
    assign tx_out     = r_tx_out;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_byte_tx
// Brief    : Self-checking bench for uart_byte_tx against a frame-timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_byte_tx;

    localparam int N     = 4;
    localparam int N_BIG = 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ld_tx_data = 1'b0;
    logic       tx_enable = 1'b0;
    logic       tx_empty, tx_busy, tx_overrun, tx_out;

    logic [7:0] b_data = 8'h00;
    logic       b_ld = 1'b0;
    logic       b_en = 1'b0;
    logic       b_empty, b_busy, b_overrun, b_out;

    int total = 0;
    int bad   = 0;

    uart_byte_tx #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .ld_tx_data (ld_tx_data),
        .tx_enable  (tx_enable),
        .tx_empty   (tx_empty),
        .tx_busy    (tx_busy),
        .tx_overrun (tx_overrun),
        .tx_out     (tx_out)
    );

    uart_byte_tx dut_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (b_data),
        .ld_tx_data (b_ld),
        .tx_enable  (b_en),
        .tx_empty   (b_empty),
        .tx_busy    (b_busy),
        .tx_overrun (b_overrun),
        .tx_out     (b_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame started by a transfer at edge X shows frame bit k
    // on the line for the N samples after edges X+1+k*N .. X+(k+1)*N.
    longint     e_cnt = 0;
    longint     m_start = -1000000;
    longint     m_prev_start = -1000000;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] m_shift = 8'h00;
    logic [7:0] m_prev_shift = 8'h00;
    logic       m_empty = 1'b1;
    logic       m_ovr = 1'b0;
    int         busy_cnt = 0;

    function automatic logic frame_bit(input logic [7:0] b, input longint d);
        int k;
        k = int'((d - 1) / N);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk) begin : model
        logic   xfer, ld_ok, exp_out, exp_busy;
        longint d, dp;
        e_cnt++;
        if (!rst_n) begin
            m_start      = -1000000;
            m_prev_start = -1000000;
            m_hold       = 8'h00;
            m_empty      = 1'b1;
            m_ovr        = 1'b0;
        end else begin
            xfer  = !m_empty && tx_enable && (e_cnt >= m_start + 10 * N);
            ld_ok = ld_tx_data && m_empty;
            if (ld_tx_data && !m_empty) m_ovr = 1'b1;
            if (xfer) begin
                m_prev_start = m_start;
                m_prev_shift = m_shift;
                m_start      = e_cnt;
                m_shift      = m_hold;
                m_empty      = 1'b1;
            end else if (ld_ok) begin
                m_hold  = tx_data;
                m_empty = 1'b0;
            end
        end
        #1;
        d  = e_cnt - m_start;
        dp = e_cnt - m_prev_start;
        exp_out  = 1'b1;
        exp_busy = 1'b0;
        if (d >= 1 && d <= 10 * N) begin
            exp_out  = frame_bit(m_shift, d);
            exp_busy = 1'b1;
        end else if (dp >= 1 && dp <= 10 * N) begin
            exp_out  = frame_bit(m_prev_shift, dp);
            exp_busy = 1'b1;
        end
        check("tx_out", tx_out, exp_out);
        check("tx_busy", tx_busy, exp_busy);
        check("tx_empty", tx_empty, m_empty);
        check("tx_overrun", tx_overrun, m_ovr);
        if (tx_busy === 1'b1) busy_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] b);
        tx_data    = b;
        ld_tx_data = 1'b1;
        @(negedge clk);
        ld_tx_data = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (tx_empty !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_empty_timeout", tx_empty, 1'b1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lo, hi;
        idle(3);
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_tx_empty", tx_empty, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_tx_overrun", tx_overrun, 1'b0);
        rst_n     = 1'b1;
        tx_enable = 1'b1;
        idle(2);

        busy_cnt = 0;
        load(8'hA5);
        idle(50);
        check("a5_busy_len", busy_cnt, 40);

        busy_cnt = 0;
        load(8'h55);
        wait_empty(20);
        load(8'h0F);
        idle(100);
        check("b2b_busy_len", busy_cnt, 80);

        load(8'h11);
        load(8'h22);
        idle(50);
        check("ovr_sticky", tx_overrun, 1'b1);

        tx_enable = 1'b0;
        load(8'h3C);
        idle(30);
        check("en_low_held", tx_empty, 1'b0);
        tx_enable = 1'b1;
        idle(2 + 3 * N);
        tx_enable = 1'b0;
        idle(50);
        tx_enable = 1'b1;
        idle(2);

        load(8'hC3);
        idle(4 * N + 3);
        check("pre_rst_busy", tx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out", tx_out, 1'b1);
        check("async_rst_empty", tx_empty, 1'b1);
        check("async_rst_busy", tx_busy, 1'b0);
        check("async_rst_ovr", tx_overrun, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        load(8'h96);
        idle(50);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) tx_enable = ~tx_enable;
            ld_tx_data = ($urandom_range(0, 7) == 0);
            tx_data    = 8'($urandom);
            rst_n      = ($urandom_range(0, 999) != 0);
            @(negedge clk);
        end
        ld_tx_data = 1'b0;
        rst_n      = 1'b1;
        tx_enable  = 1'b1;
        idle(60);

        b_en   = 1'b1;
        b_data = 8'h00;
        b_ld   = 1'b1;
        @(negedge clk);
        b_ld = 1'b0;
        lo = 0;
        while (b_out !== 1'b0 && lo < 10) begin
            @(posedge clk);
            #1;
            lo++;
        end
        check("big_start_seen", b_out, 1'b0);
        lo = 0;
        while (b_out === 1'b0 && lo < 5000) begin
            lo++;
            @(posedge clk);
            #1;
        end
        check("big_low_len", lo, 9 * N_BIG);
        hi = 0;
        while (b_busy === 1'b1 && b_out === 1'b1 && hi < 1000) begin
            hi++;
            @(posedge clk);
            #1;
        end
        check("big_stop_len", hi, N_BIG);
        check("big_idle_out", b_out, 1'b1);
        check("big_idle_busy", b_busy, 1'b0);
        check("big_empty", b_empty, 1'b1);
        check("big_overrun", b_overrun, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
